hex_count_scheduler: RTL and testbench

Shares one 4-bit hex up-counter between NUM_REQ requesters, each asking for a timed interval of req_len clock ticks.
- Round-robin arbitration picks the winner; the block loads and runs the counter, then pulses done back to the winner.
- Sits between client control FSMs and the shared counter datapath; it is the counter's only sequencer.

---
 rtl/hex_count_scheduler_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/hex_count_scheduler.sv | 79 +++++++
 tb/tb_hex_count_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/hex_count_scheduler_pkg.sv
// hex_count_scheduler_pkg: shared state encoding and default width for the counter scheduler
package hex_count_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from rr_ptr with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      index,
    output logic               any
);

    always_comb begin
        int k;
        k = 0;
        onehot = '0;
        index = '0;
        any = 1'b0;
        // Scan from the farthest offset down so the closest-to-rr_ptr requester wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (req[k]) begin
                onehot = '0;
                onehot[k] = 1'b1;
                index = k[IW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_count_scheduler.sv
// hex_count_scheduler: shares one up-counter between NUM_REQ requesters, round-robin,
// loading each winner's length and pulsing done on completion.
module hex_count_scheduler
    import hex_count_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_len,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [WIDTH-1:0]         count,
    output logic [NUM_REQ-1:0]       done
);

    localparam int IW = $clog2(NUM_REQ);

    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, owner, win_idx, nxt_ptr;
    logic [NUM_REQ-1:0] win_oh;
    logic win_any, at_target;
    logic [WIDTH-1:0] target;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) arb (
        .req(req),
        .rr_ptr(rr_ptr),
        .onehot(win_oh),
        .index(win_idx),
        .any(win_any)
    );

    assign busy = state != ST_IDLE;
    assign at_target = count == target;
    assign nxt_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nx = (state == ST_IDLE) ? (win_any ? ST_RUN : ST_IDLE) :
                   (state == ST_RUN)  ? (abort ? ST_IDLE : at_target ? ST_DONE : ST_RUN) :
                   ST_IDLE;
    end

    // Abort takes priority over completion; both release the owner and advance rr_ptr.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= '0;
            count <= '0;
            done <= '0;
            rr_ptr <= '0;
            target <= '0;
            owner <= '0;
        end else begin
            state <= state_nx;
            done <= '0;
            if (state == ST_IDLE && win_any) begin
                grant <= win_oh;
                owner <= win_idx;
                target <= req_len[int'(win_idx)*WIDTH +: WIDTH];
                count <= '0;
            end else if (state == ST_RUN) begin
                if (abort) begin
                    grant <= '0;
                    rr_ptr <= nxt_ptr;
                end else if (at_target) begin
                    grant <= '0;
                    done <= grant;
                    rr_ptr <= nxt_ptr;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_count_scheduler.sv
// tb_hex_count_scheduler: directed vectors with hand-computed expectations for the counter scheduler
module tb_hex_count_scheduler;

    localparam int NUM_REQ = 2;
    localparam int WIDTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic abort = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ*WIDTH-1:0] req_len = '0;
    logic [NUM_REQ-1:0] grant, done;
    logic busy;
    logic [WIDTH-1:0] count;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    hex_count_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .req_len(req_len),
        .abort(abort),
        .grant(grant),
        .busy(busy),
        .count(count),
        .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic b,
                             input logic [3:0] c, input logic [1:0] d);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".done"}, 32'(done), 32'(d));
    endtask

    function automatic logic [1:0] rr_done(input int c);
        return (c == 4 || c == 15) ? 2'b01 : (c == 10 || c == 21) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] rr_grant(input int c);
        return ((c >= 1 && c <= 3) || (c >= 12 && c <= 14)) ? 2'b01 :
               ((c >= 6 && c <= 9) || (c >= 17 && c <= 20)) ? 2'b10 : 2'b00;
    endfunction

    initial begin
        // Reset held, then idle with no requests
        repeat (3) step();
        check_all("reset", 2'b00, 1'b0, 4'd0, 2'b00);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_all("idle", 2'b00, 1'b0, 4'd0, 2'b00);
        end

        // Single request, len 5; length change after grant must be ignored
        req = 2'b01;
        req_len = {4'd0, 4'd5};
        step();
        check_all("single.grant", 2'b01, 1'b1, 4'd0, 2'b00);
        req_len = {4'd0, 4'd1};
        for (int k = 1; k <= 5; k++) begin
            step();
            check_all("single.run", 2'b01, 1'b1, 4'(k), 2'b00);
        end
        step();
        check_all("single.done", 2'b00, 1'b1, 4'd5, 2'b01);
        req = 2'b00;
        step();
        check_all("single.idle", 2'b00, 1'b0, 4'd5, 2'b00);

        // Fresh rr_ptr, then alternate two requesters with lens 2 and 3
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 2'b11;
        req_len = {4'd3, 4'd2};
        for (int c = 1; c <= 21; c++) begin
            step();
            check($sformatf("rr.grant@%0d", c), 32'(grant), 32'(rr_grant(c)));
            check($sformatf("rr.done@%0d", c), 32'(done), 32'(rr_done(c)));
            req = (rr_done(c) != 2'b00) ? (2'b11 & ~rr_done(c)) : 2'b11;
        end
        req = 2'b00;
        step();
        check_all("rr.idle", 2'b00, 1'b0, 4'd3, 2'b00);

        // len 0: done two cycles after the request
        req = 2'b01;
        req_len = {4'd0, 4'd0};
        step();
        check_all("len0.grant", 2'b01, 1'b1, 4'd0, 2'b00);
        step();
        check_all("len0.done", 2'b00, 1'b1, 4'd0, 2'b01);
        req = 2'b00;
        step();

        // len 15 on requester 1: full range with no wrap
        req = 2'b10;
        req_len = {4'd15, 4'd0};
        step();
        check_all("len15.grant", 2'b10, 1'b1, 4'd0, 2'b00);
        for (int k = 1; k <= 15; k++) begin
            step();
            check_all("len15.run", 2'b10, 1'b1, 4'(k), 2'b00);
        end
        step();
        check_all("len15.done", 2'b00, 1'b1, 4'hF, 2'b10);
        req = 2'b00;
        step();
        check_all("len15.idle", 2'b00, 1'b0, 4'hF, 2'b00);

        // Abort at count 3 of a len-9 run; the other requester follows
        req = 2'b11;
        req_len = {4'd9, 4'd9};
        step();
        check_all("abort.grant", 2'b01, 1'b1, 4'd0, 2'b00);
        for (int k = 1; k <= 3; k++) begin
            step();
            check_all("abort.run", 2'b01, 1'b1, 4'(k), 2'b00);
        end
        abort = 1'b1;
        step();
        check_all("abort.idle", 2'b00, 1'b0, 4'd3, 2'b00);
        abort = 1'b0;
        step();
        check_all("abort.next", 2'b10, 1'b1, 4'd0, 2'b00);

        // Reset mid-run at count 6, then rr_ptr must be back at 0
        for (int k = 1; k <= 6; k++) begin
            step();
            check_all("rst.run", 2'b10, 1'b1, 4'(k), 2'b00);
        end
        reset = 1'b1;
        step();
        check_all("rst.clear", 2'b00, 1'b0, 4'd0, 2'b00);
        reset = 1'b0;
        step();
        check_all("rst.regrant", 2'b01, 1'b1, 4'd0, 2'b00);
        req = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
